// File: rtl/spi_slave_rx_pkg.sv
// Constants and types shared by the SPI receive path and the transmit driver.
// A word is {dc, data}, with dc in the top bit.
package spi_slave_rx_pkg;

   localparam int   SPI_DATA_SIZE = 9;
   localparam int   SPI_DC_BIT    = SPI_DATA_SIZE - 1;
   localparam logic SPI_DC_CMD    = 1'b0;
   localparam logic SPI_DC_DATA   = 1'b1;

   typedef enum logic [0:0] {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundles the 4-wire SPI bus and the received-word stream.
// The slave modport is the receiver's view; the master modport drives the bus and consumes the words.
interface spi_slave_rx_if
   import spi_slave_rx_pkg::*;
#(
   parameter int DATA_SIZE = SPI_DATA_SIZE
) ();

   logic                 spi_sck;
   logic                 spi_mosi;
   logic                 spi_dc;
   logic                 spi_cs;
   logic [DATA_SIZE-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 overflow;
   logic                 frame_error;
   logic                 busy;

   modport slave (
      input  spi_sck, spi_mosi, spi_dc, spi_cs, out_ready,
      output out_data, out_valid, overflow, frame_error, busy
   );

   modport master (
      output spi_sck, spi_mosi, spi_dc, spi_cs, out_ready,
      input  out_data, out_valid, overflow, frame_error, busy
   );

endinterface

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO for received words.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spi_rx_fifo
   import spi_slave_rx_pkg::*;
#(
   parameter int WIDTH = SPI_DATA_SIZE,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full,
   output logic             o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_empty = (r_count == {CNT_W{1'b0}});
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_pop   = i_pop & ~w_empty;
   assign w_push  = i_push & (~w_full | w_pop);

   // Occupancy update.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage array; contents are only observable through the masked read port.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers, occupancy and the overflow pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count    <= w_count_nxt;
         r_overflow <= i_push & w_full & ~w_pop;
      end
   end

   assign o_data     = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
   assign o_valid    = ~w_empty;
   assign o_full     = w_full;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receiver: synchronizes SCK/MOSI/DC/CS into clk, deserializes {dc, byte} frames
// and queues the finished words on a valid/ready stream.
module spi_slave_rx
   import spi_slave_rx_pkg::*;
#(
   parameter int DATA_SIZE   = SPI_DATA_SIZE,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   spi_slave_rx_if.slave bus
);

   localparam int                 CNT_W    = $clog2(DATA_SIZE);
   localparam int                 SR_W     = DATA_SIZE - 2;
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DATA_SIZE - 2);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_dc_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;

   logic                 r_sck_d;
   logic                 r_cs_d;
   logic                 r_sck_rise;
   logic                 r_cs_rise;
   logic                 r_cs_fall;
   logic                 r_mosi_e;
   logic                 r_dc_e;

   rx_state_e            r_state;
   rx_state_e            w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [SR_W-1:0]      r_shift;
   logic [SR_W-1:0]      w_shift_nxt;
   logic                 w_complete;
   logic                 w_frame_err;
   logic [DATA_SIZE-1:0] w_word;

   logic                 r_push;
   logic [DATA_SIZE-1:0] r_word;
   logic                 r_frame_err;
   logic                 r_busy;

   logic                 w_sck_s;
   logic                 w_cs_s;
   logic [DATA_SIZE-1:0] w_fifo_data;
   logic                 w_fifo_valid;
   logic                 w_fifo_full;
   logic                 w_fifo_ovf;

   assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];

   // Identical synchronizer chains keep MOSI/DC aligned with the SCK edge they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_sync  <= {SYNC_STAGES{1'b0}};
         r_mosi_sync <= {SYNC_STAGES{1'b0}};
         r_dc_sync   <= {SYNC_STAGES{1'b0}};
         r_cs_sync   <= {SYNC_STAGES{1'b1}};
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  bus.spi_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   bus.spi_dc};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs};
      end
   end

   // Edge detection, registered together with the data bits captured at that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_d    <= 1'b0;
         r_cs_d     <= 1'b1;
         r_sck_rise <= 1'b0;
         r_cs_rise  <= 1'b0;
         r_cs_fall  <= 1'b0;
         r_mosi_e   <= 1'b0;
         r_dc_e     <= 1'b0;
      end else begin
         r_sck_d    <= w_sck_s;
         r_cs_d     <= w_cs_s;
         r_sck_rise <= w_sck_s & ~r_sck_d;
         r_cs_rise  <= w_cs_s & ~r_cs_d;
         r_cs_fall  <= ~w_cs_s & r_cs_d;
         r_mosi_e   <= r_mosi_sync[SYNC_STAGES-1];
         r_dc_e     <= r_dc_sync[SYNC_STAGES-1];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RX_IDLE: begin
            if (r_cs_fall) begin
               w_state_nxt = RX_SHIFT;
            end else begin
               w_state_nxt = RX_IDLE;
            end
         end
         RX_SHIFT: begin
            if (r_cs_rise) begin
               w_state_nxt = RX_IDLE;
            end else begin
               w_state_nxt = RX_SHIFT;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   // FSM outputs: the SCK edge is applied before the CS-rise frame check.
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_complete  = 1'b0;
      w_frame_err = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (r_cs_fall) begin
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_shift_nxt = {SR_W{1'b0}};
            end else begin
               w_cnt_nxt   = r_cnt;
            end
         end
         RX_SHIFT: begin
            if (r_sck_rise) begin
               w_shift_nxt = {r_shift[SR_W-2:0], r_mosi_e};
               if (r_cnt == LAST_CNT) begin
                  w_complete = 1'b1;
                  w_cnt_nxt  = {CNT_W{1'b0}};
               end else begin
                  w_cnt_nxt  = r_cnt + CNT_W'(1);
               end
            end else begin
               w_shift_nxt = r_shift;
            end
            if (r_cs_rise) begin
               w_frame_err = (w_cnt_nxt != {CNT_W{1'b0}});
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_frame_err = 1'b0;
            end
         end
         default: begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_shift_nxt = {SR_W{1'b0}};
         end
      endcase
      w_word = {r_dc_e, r_shift, r_mosi_e};
   end

   // Shift datapath, push request and frame-error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= {CNT_W{1'b0}};
         r_shift     <= {SR_W{1'b0}};
         r_push      <= 1'b0;
         r_word      <= {DATA_SIZE{1'b0}};
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_push      <= w_complete;
         r_frame_err <= w_frame_err;
         r_busy      <= ~w_cs_s | (r_state == RX_SHIFT) | (r_cnt != {CNT_W{1'b0}});
         if (w_complete) begin
            r_word <= w_word;
         end
      end
   end

   spi_rx_fifo #(
      .WIDTH (DATA_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_push     (r_push),
      .i_data     (r_word),
      .i_pop      (bus.out_ready),
      .o_data     (w_fifo_data),
      .o_valid    (w_fifo_valid),
      .o_full     (w_fifo_full),
      .o_overflow (w_fifo_ovf)
   );

   assign bus.out_data    = w_fifo_data;
   assign bus.out_valid   = w_fifo_valid;
   assign bus.overflow    = w_fifo_ovf;
   assign bus.frame_error = r_frame_err;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives the SPI bus from tasks and checks received words and pulses.
module tb_spi_slave_rx;

   localparam int DS = 9;
   localparam int SS = 2;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   n_fe;
   int   n_ovf;
   logic [DS-1:0] rxq [$];

   spi_slave_rx_if #(.DATA_SIZE(DS)) bus ();

   spi_slave_rx #(
      .DATA_SIZE   (DS),
      .FIFO_DEPTH  (4),
      .SYNC_STAGES (SS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor samples 1 time unit before each rising edge.
   initial begin
      n_fe  = 0;
      n_ovf = 0;
      forever begin
         @(negedge clk);
         #4;
         if (bus.out_valid && bus.out_ready) rxq.push_back(bus.out_data);
         if (bus.frame_error) n_fe = n_fe + 1;
         if (bus.overflow) n_ovf = n_ovf + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rx_at(input int idx);
      if (idx < rxq.size()) return 32'(rxq[idx]);
      return 32'hDEAD_BEEF;
   endfunction

   task automatic spi_bit(input logic b, input logic d, input int half);
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = b;
      bus.spi_dc   = d;
      repeat (half) @(negedge clk);
      bus.spi_sck  = 1'b1;
      repeat (half) @(negedge clk);
   endtask

   task automatic send_word(input logic d, input logic [7:0] b, input int half);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], d, half);
   endtask

   task automatic cs_low();
      bus.spi_sck = 1'b0;
      bus.spi_cs  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic cs_high(input int settle);
      bus.spi_sck = 1'b0;
      bus.spi_cs  = 1'b1;
      repeat (settle) @(negedge clk);
   endtask

   initial begin
      int base;
      int fe0;
      int ov0;
      int n;
      logic [7:0] b;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.spi_sck = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.spi_dc = 1'b0;
      bus.spi_cs = 1'b1;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_data", 32'(bus.out_data), 32'd0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rst_ferr", 32'(bus.frame_error), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Two words, command then data.
      bus.out_ready = 1'b1;
      base = rxq.size(); fe0 = n_fe; ov0 = n_ovf;
      cs_low();
      repeat (2) @(negedge clk);
      check_eq("busy_cs_low", 32'(bus.busy), 32'd1);
      send_word(1'b0, 8'h2A, 2);
      send_word(1'b1, 8'h55, 2);
      cs_high(12);
      check_eq("ab_count", 32'(rxq.size() - base), 32'd2);
      check_eq("ab_w0", rx_at(base), 32'h02A);
      check_eq("ab_w1", rx_at(base + 1), 32'h155);
      check_eq("ab_ferr", 32'(n_fe - fe0), 32'd0);
      check_eq("ab_ovf", 32'(n_ovf - ov0), 32'd0);
      check_eq("busy_idle", 32'(bus.busy), 32'd0);

      // Latency from the final SCK rising edge to out_valid.
      base = rxq.size();
      cs_low();
      b = 8'h3C;
      for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b0, 2);
      bus.spi_sck = 1'b0;
      bus.spi_mosi = b[0];
      repeat (2) @(negedge clk);
      bus.spi_sck = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n = n + 1;
      end while (!bus.out_valid && n < 20);
      check_eq("latency", 32'(n), 32'(SS + 3));
      @(negedge clk);
      cs_high(10);
      check_eq("lat_word", rx_at(base), 32'h03C);

      // Twenty back-to-back words at SCK = clk/2.
      base = rxq.size();
      cs_low();
      for (int i = 0; i < 20; i++) begin
         b = 8'(i * 37 + 5);
         send_word(i[0], b, 1);
      end
      cs_high(12);
      check_eq("b2b_count", 32'(rxq.size() - base), 32'd20);
      for (int i = 0; i < 20; i++) begin
         b = 8'(i * 37 + 5);
         check_eq($sformatf("b2b_w%0d", i), rx_at(base + i), 32'({i[0], b}));
      end

      // Partial frame, then a clean frame.
      base = rxq.size(); fe0 = n_fe;
      cs_low();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1, 2);
      cs_high(10);
      check_eq("ferr_pulse", 32'(n_fe - fe0), 32'd1);
      check_eq("ferr_noword", 32'(rxq.size() - base), 32'd0);
      cs_low();
      send_word(1'b1, 8'hFF, 2);
      cs_high(10);
      check_eq("ferr_next", rx_at(base), 32'h1FF);
      check_eq("ferr_once", 32'(n_fe - fe0), 32'd1);

      // Overflow with the consumer stalled.
      bus.out_ready = 1'b0;
      base = rxq.size(); ov0 = n_ovf;
      cs_low();
      send_word(1'b0, 8'h11, 2);
      send_word(1'b1, 8'h22, 2);
      send_word(1'b0, 8'h33, 2);
      send_word(1'b1, 8'h44, 2);
      send_word(1'b0, 8'h55, 2);
      cs_high(10);
      check_eq("ovf_pulse", 32'(n_ovf - ov0), 32'd1);
      check_eq("ovf_valid", 32'(bus.out_valid), 32'd1);
      check_eq("ovf_head", 32'(bus.out_data), 32'h011);
      bus.out_ready = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("ovf_count", 32'(rxq.size() - base), 32'd4);
      check_eq("ovf_w0", rx_at(base), 32'h011);
      check_eq("ovf_w1", rx_at(base + 1), 32'h122);
      check_eq("ovf_w2", rx_at(base + 2), 32'h033);
      check_eq("ovf_w3", rx_at(base + 3), 32'h144);
      check_eq("ovf_empty", 32'(bus.out_valid), 32'd0);

      // Reset mid-frame with words queued.
      bus.out_ready = 1'b0;
      cs_low();
      send_word(1'b0, 8'hA1, 2);
      send_word(1'b1, 8'hB2, 2);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, 2);
      check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_mid_data", 32'(bus.out_data), 32'd0);
      bus.spi_cs = 1'b1;
      bus.spi_sck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.out_ready = 1'b1;
      base = rxq.size(); fe0 = n_fe;
      cs_low();
      send_word(1'b0, 8'hC3, 2);
      cs_high(10);
      check_eq("post_rst_count", 32'(rxq.size() - base), 32'd1);
      check_eq("post_rst_word", rx_at(base), 32'h0C3);
      check_eq("post_rst_ferr", 32'(n_fe - fe0), 32'd0);

      // SCK toggling with CS high is ignored.
      base = rxq.size(); fe0 = n_fe; ov0 = n_ovf;
      for (int i = 0; i < 12; i++) spi_bit(i[0], 1'b1, 2);
      bus.spi_sck = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("cs_hi_words", 32'(rxq.size() - base), 32'd0);
      check_eq("cs_hi_ferr", 32'(n_fe - fe0), 32'd0);
      check_eq("cs_hi_ovf", 32'(n_ovf - ov0), 32'd0);

      // Final SCK rise coincident with CS rise completes the word.
      base = rxq.size(); fe0 = n_fe;
      cs_low();
      b = 8'hA5;
      for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b1, 2);
      bus.spi_sck = 1'b0;
      bus.spi_mosi = b[0];
      repeat (2) @(negedge clk);
      bus.spi_sck = 1'b1;
      bus.spi_cs = 1'b1;
      repeat (12) @(negedge clk);
      bus.spi_sck = 1'b0;
      check_eq("coinc_count", 32'(rxq.size() - base), 32'd1);
      check_eq("coinc_word", rx_at(base), 32'h1A5);
      check_eq("coinc_ferr", 32'(n_fe - fe0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side counterpart of the display SPI link: samples an externally driven 4-wire SPI bus (SCK, MOSI, DC, active-low CS) in the system clock domain and deserializes each frame into a `{dc, byte}` word. Received words are buffered in a small FIFO and presented on a valid/ready stream. It serves as the bus monitor and loopback checker for the ILI9341 driver path, and as the front end for any SPI-controlled peripheral in the design.

## Interface
- `DATA_SIZE`, 9: word width; bit `DATA_SIZE-1` is DC, bits `DATA_SIZE-2:0` are serial data (8 bits per frame by default).
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.
- `SYNC_STAGES`, 2: synchronizer flops on every bus input; ≥ 2.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `spi_sck` in 1: serial clock, asynchronous to `clk`.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_dc` in 1: data/command flag, 1 = data, 0 = command.
- `spi_cs` in 1: chip select, active low.
- `out_data` out `DATA_SIZE`: FIFO head word `{dc, data}`.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts head word when high with `out_valid`.
- `overflow` out 1: one-cycle pulse, completed word dropped because FIFO full.
- `frame_error` out 1: one-cycle pulse, CS deasserted mid-frame.
- `busy` out 1: CS asserted (synchronized) or partial frame held.

## Operation
- All four bus inputs pass through identical `SYNC_STAGES` chains; edge detection uses one further register on synchronized SCK and CS.
- States: IDLE (CS high), SHIFT (CS low, counting bits). IDLE→SHIFT on synchronized CS falling edge: bit counter and shift register cleared. SHIFT→IDLE on CS rising edge.
- In SHIFT, each synchronized SCK rising edge shifts MOSI into the shift register LSB (MSB first on wire) and increments the bit counter.
- On the `DATA_SIZE-1`th rising edge: DC sampled at that same edge forms bit `DATA_SIZE-1`; word pushed to FIFO; counter wraps to 0. Back-to-back frames within one CS assertion are allowed.
- SCK edges while CS high are ignored. SCK falling edges are ignored.
- CS rising edge with counter in 1..`DATA_SIZE-2`: partial frame discarded, `frame_error` pulses. Counter 0: no error.
- CS rising and SCK rising detected in the same cycle: the SCK edge is processed first (bit counted, word pushed if it completes the frame), then the CS check is applied.
- FIFO push when full: word dropped, `overflow` pulses, contents unchanged. Push and pop in the same cycle while full: both succeed, no overflow. Pop when empty: no effect.
- Counters use widths `$clog2(DATA_SIZE)` and `$clog2(FIFO_DEPTH)+1`; pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `overflow` 0, `frame_error` 0, `busy` 0; FIFO empty, state IDLE, synchronizers 0 except CS chain 1.
- Reset mid-frame or with a non-empty FIFO: all state discarded immediately. The first frame after reset requires a fresh CS falling edge.
- Latency: `out_valid` rises `SYNC_STAGES`+2 `clk` cycles after the `clk` edge at which the final SCK rising edge is first registered, with an empty FIFO.
- Bus constraint: every SCK high and low phase, and MOSI/DC setup before SCK rising, is ≥ 1 `clk` period. This covers SCK = `clk`/2 from the driver.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.
- `frame_error` and `overflow` pulse exactly one cycle per event.

## Structure
- Shared package constants: `SPI_DC_BIT` = `DATA_SIZE-1`, default `DATA_SIZE` = 9, command/data encoding (DC 0/1). These are shared with the transmit driver.
- One sub-module: `spi_rx_fifo`, a synchronous FIFO with push/pop, full/empty, and same-cycle push+pop when full. The top holds the synchronizers, edge detection, FSM and shift logic.

## Test plan
- CS low, send DC=0 byte 0x2A, then DC=1 byte 0x55, CS high, `out_ready`=1 → words 0x02A then 0x155 appear in order; no error pulses.
- Drive with the transmit driver at SCK = `clk`/2 over 20 back-to-back words → every word received bit-exact.
- CS high after 5 bits → `frame_error` one pulse, no word pushed. Next full frame 0x1FF → received correctly.
- `out_ready`=0, send 5 words with `FIFO_DEPTH`=4 → first 4 words held, `overflow` pulses once on word 5. Drain → 4 original words in order.
- Assert `rst` after 4 bits with 2 words queued → `out_valid` 0 immediately. Post-reset frame 0x0C3 → single word 0x0C3.
- SCK toggling with CS high → no words and no pulses. Final SCK rising edge coincident with CS rising → word pushed, no `frame_error`.
